// File: rtl/alu_decode_stage_pkg.sv
// Shared encodings for the decode stage: ALU function codes, RV32I opcodes,
// operand-A selects and the decoded bundle carried through the stage.
package alu_decode_stage_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ASEL_RS1  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;

    typedef struct packed {
        logic [3:0]  alufn;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic        swap;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
        logic [31:0] pc;
    } bundle_t;

    // Register/immediate arithmetic shares funct3; alt selects SUB/SRA.
    function automatic logic [3:0] f3_alufn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Fetch-side and execute-side handshake of the decode stage. The stage
// itself uses 'slave'; whatever drives fetch and consumes bundles uses 'master'.
interface alu_decode_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alufn;
    logic [1:0]  out_a_sel;
    logic        out_b_sel;
    logic        out_swap;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;
    logic [31:0] out_pc;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_alufn, out_a_sel, out_b_sel, out_swap,
               out_imm, out_rs1, out_rs2, out_rd, out_we, out_illegal, out_pc
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_alufn, out_a_sel, out_b_sel, out_swap,
               out_imm, out_rs1, out_rs2, out_rd, out_we, out_illegal, out_pc
    );
endinterface

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32I decode: instruction word -> ALU control bundle.
// Illegal encodings come out as a clean ADD bundle with every select at zero.
module alu_decode_comb
    import alu_decode_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output bundle_t     bundle_o
);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal, wr;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'h000};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        bundle_o     = '0;
        bundle_o.rs1 = instr_i[19:15];
        bundle_o.rs2 = instr_i[24:20];
        bundle_o.rd  = instr_i[11:7];
        bundle_o.pc  = pc_i;
        legal        = 1'b1;
        wr           = 1'b0;
        case (opc)
            OPC_OP: begin
                bundle_o.alufn = f3_alufn(f3, f7[5]);
                bundle_o.swap  = (f3 == 3'b010) || (f3 == 3'b011);
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                wr    = 1'b1;
            end
            OPC_OPIMM: begin
                bundle_o.alufn = f3_alufn(f3, (f3 == 3'b101) && f7[5]);
                bundle_o.swap  = (f3 == 3'b010) || (f3 == 3'b011);
                bundle_o.b_sel = 1'b1;
                bundle_o.imm   = imm_i;
                if (f3 == 3'b001)      legal = (f7 == 7'h00);
                else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
                wr = 1'b1;
            end
            OPC_LUI: begin
                // A forced to zero so the bundle is also correct as an ADD.
                bundle_o.alufn = ALU_PASS;
                bundle_o.a_sel = ASEL_ZERO;
                bundle_o.b_sel = 1'b1;
                bundle_o.imm   = imm_u;
                wr = 1'b1;
            end
            OPC_AUIPC: begin
                bundle_o.a_sel = ASEL_PC;
                bundle_o.b_sel = 1'b1;
                bundle_o.imm   = imm_u;
                wr = 1'b1;
            end
            OPC_LOAD: begin
                bundle_o.b_sel = 1'b1;
                bundle_o.imm   = imm_i;
                legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                wr    = 1'b1;
            end
            OPC_STORE: begin
                bundle_o.b_sel = 1'b1;
                bundle_o.imm   = imm_s;
                legal = !f3[2] && (f3 != 3'b011);
            end
            OPC_JALR: begin
                bundle_o.b_sel = 1'b1;
                bundle_o.imm   = imm_i;
                legal = (f3 == 3'b000);
                wr    = 1'b1;
            end
            OPC_JAL: begin
                bundle_o.a_sel = ASEL_PC;
                bundle_o.b_sel = 1'b1;
                bundle_o.imm   = imm_j;
                wr = 1'b1;
            end
            OPC_BRANCH: begin
                bundle_o.imm = imm_b;
                case (f3[2:1])
                    2'b00:   bundle_o.alufn = ALU_SUB;
                    2'b10:   begin bundle_o.alufn = ALU_SLT;  bundle_o.swap = 1'b1; end
                    2'b11:   begin bundle_o.alufn = ALU_SLTU; bundle_o.swap = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            bundle_o.alufn = ALU_ADD;
            bundle_o.a_sel = ASEL_RS1;
            bundle_o.b_sel = 1'b0;
            bundle_o.swap  = 1'b0;
            bundle_o.imm   = '0;
        end
        bundle_o.illegal = !legal;
        bundle_o.we      = legal && wr && (bundle_o.rd != 5'd0);
    end
endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: decodes at the input, then holds bundles in a main
// register M (drives outputs) and an optional skid register S.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter bit SKID = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    alu_decode_stage_if.slave   bus
);
    bundle_t dec, m_q, m_d, s_q, s_d;
    logic    m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic    in_ready, acc, m_free;

    alu_decode_comb u_dec (
        .instr_i  (bus.in_instr),
        .pc_i     (bus.in_pc),
        .bundle_o (dec)
    );

    // With SKID, in_ready depends only on a flop, breaking the out_ready path.
    assign in_ready = SKID ? !s_vld_q : (bus.out_ready || !m_vld_q);
    assign acc      = bus.in_valid && in_ready && !bus.flush;
    assign m_free   = !m_vld_q || bus.out_ready;

    always_comb begin
        m_d     = m_q;
        s_d     = s_q;
        m_vld_d = m_vld_q;
        s_vld_d = s_vld_q;
        if (bus.flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else if (m_free) begin
            if (s_vld_q) begin
                m_d     = s_q;
                m_vld_d = 1'b1;
                s_vld_d = 1'b0;
            end else begin
                m_vld_d = acc;
                if (acc) m_d = dec;
            end
        end else if (acc && SKID) begin
            s_d     = dec;
            s_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q     <= '0;
            s_q     <= '0;
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
        end else begin
            m_q     <= m_d;
            s_q     <= s_d;
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = m_vld_q;
    assign bus.out_alufn   = m_q.alufn;
    assign bus.out_a_sel   = m_q.a_sel;
    assign bus.out_b_sel   = m_q.b_sel;
    assign bus.out_swap    = m_q.swap;
    assign bus.out_imm     = m_q.imm;
    assign bus.out_rs1     = m_q.rs1;
    assign bus.out_rs2     = m_q.rs2;
    assign bus.out_rd      = m_q.rd;
    assign bus.out_we      = m_q.we;
    assign bus.out_illegal = m_q.illegal;
    assign bus.out_pc      = m_q.pc;
endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Pipelined decode stage that sits between fetch and the ALU and produces every ALU control input: alufn, operand selects, immediate and operand-swap flag.
- It is the issuing end of the ALU control interface: it turns a fetched RV32I instruction into the alufn, operand and writeback controls the execute stage consumes.
- It is a registered valid/ready stage with a skid buffer, giving full throughput and a registered in_ready.

Parameters:
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with in_ready = out_ready | ~out_valid.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all held entries (branch redirect)
- in_valid  in  1  instruction valid from fetch
- in_ready  out  1  stage can accept an instruction
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute stage accepts bundle
- out_alufn  out  4  ALU function, encoded with the ALU_* macros in defines.v
- out_a_sel  out  2  operand A: 0 = rs1, 1 = pc, 2 = zero
- out_b_sel  out  1  operand B: 0 = rs2, 1 = imm
- out_swap  out  1  present operands to the ALU as (B, A); used for slt-class ops
- out_imm  out  32  sign-extended immediate
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_we  out  1  register write enable (forced 0 when rd = 0)
- out_illegal  out  1  unsupported opcode or funct field
- out_pc  out  32  pc passed through

Behaviour:
- Reset:
  - out_valid = 0; both entries invalid.
  - in_ready = 1.
  - All data outputs = 0, which decodes to ALU_ADD with every select at 0.
- Transfers:
  - Input transfer happens on in_valid & in_ready; output transfer happens on out_valid & out_ready.
  - Latency is 1 cycle from input transfer to out_valid. Throughput is 1 instruction per cycle when out_ready = 1.
- Skid buffer (SKID = 1): main register M drives the outputs; skid register S holds overflow.
  - in_ready = ~S.valid, registered.
  - Accept with M empty or M draining -> load into M.
  - Accept with M full and stalled -> load into S.
  - M drains while S full -> S moves to M and S clears.
  - Ordering is strictly FIFO.
  - Data outputs hold stable while out_valid & ~out_ready.
- Flush:
  - Clears M.valid and S.valid on the next edge.
  - An instruction presented in the same cycle is dropped, even if in_ready = 1; flush wins.
- Decode map (alufn / a_sel / b_sel / swap):
  - OP (0110011): ADD or SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL or SRA (funct7[5]), OR, AND; b_sel = rs2. SLT and SLTU set swap = 1 because the ALU evaluates a > b.
  - OP-IMM (0010011): same functions with b_sel = imm. SLTI/SLTIU set swap = 1. SUB is not encodable here. Shifts with funct7 other than 0000000 or 0100000 (SRAI) -> illegal.
  - LUI: PASS, b = imm (imm = instr[31:12] << 12).
  - AUIPC: ADD, a = pc, b = imm.
  - LOAD, STORE, JALR: ADD, a = rs1, b = imm (I-type or S-type immediate).
  - JAL: ADD, a = pc, b = imm (J-type immediate).
  - BRANCH:
    - BEQ/BNE -> SUB, b = rs2.
    - BLT/BGE -> SLT, swap = 1.
    - BLTU/BGEU -> SLTU, swap = 1.
    - imm = B-type immediate.
    - out_we = 0.
  - STORE: out_we = 0.
  - Any other opcode, or an undefined funct3/funct7 combination:
    - out_illegal = 1, out_we = 0, alufn = ADD.
    - The bundle still flows through the stage.
- All immediates are sign-extended from instr[31].

Decomposition:
- The opcode constants (OPC_OP, OPC_OPIMM, …) and the a_sel encodings go in defines.v alongside the existing ALU_* macros.
- Sub-module alu_decode_comb: purely combinational, instr -> bundle.
- alu_decode_stage instantiates it once at the input, so both M and S store already-decoded bundles.

Test Plan:
- Back-to-back: 0x002081B3 then 0x407302B3 with out_ready = 1 -> cycle 1: ADD, rs1 = 1, rs2 = 2, rd = 3, we = 1; cycle 2: SUB, rd = 5. No bubbles.
- 0xFFF00093 (addi x1, x0, -1) -> ADD, b_sel = 1, imm = 0xFFFFFFFF, rd = 1. Then 0x40315113 -> SRA, imm[4:0] = 3.
- 0x0020C463 (blt x1, x2, 8) -> SLT, swap = 1, imm = 8, we = 0. Then 0x12345237 -> PASS, imm = 0x12345000.
- Stall: out_ready = 0 for 3 cycles while feeding 3 instructions -> first held in M, second in S, in_ready = 0. Release -> FIFO order preserved, no loss or duplication.
- Flush with M and S full and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, no instruction emitted. Assert rst mid-stall -> all outputs return to reset values immediately.
- Opcode 0x7F and add with funct7 = 0x01 -> out_illegal = 1, we = 0, alufn = ADD.
